key_schedule_seq: RTL and testbench

//  Sequential, parametrised successor to the combinational one-round key schedule.

---
 rtl/key_schedule_seq.sv | 187 ++++++++++++++++++
 tb/tb_key_schedule_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_seq.sv
`default_nettype none
// ============================================================================
//  Module      : key_schedule_seq
//  Description : Sequential DES-style key schedule. Loads one 56-bit post-PC1
//                key and emits ROUNDS 48-bit round keys over a valid/ready
//                handshake, in forward (encrypt) or reverse (decrypt) order.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_schedule_seq #(
  parameter int          ROUNDS    = 16,
  parameter logic [15:0] SHIFT_MAP = 16'h7EFC,
  parameter int          IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid_i,
  output logic             key_ready_o,
  input  logic [55:0]      key_i,
  input  logic             dec_i,
  input  logic             abort_i,
  output logic             k_valid_o,
  input  logic             k_ready_i,
  output logic [47:0]      k_o,
  output logic [IDX_W-1:0] k_idx_o,
  output logic             k_last_o,
  output logic [55:0]      r_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Index of the final round key in forward order.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  // Rotation applied by round 'idx': 2 when its SHIFT_MAP bit is set, else 1.
  function automatic int shift_of(input logic [IDX_W-1:0] idx);
    logic [15:0] m;
    m = SHIFT_MAP >> idx;
    return m[0] ? 2 : 1;
  endfunction

  // Sum of all per-round shifts, folded into one 28-bit rotation.
  function automatic int total_shift();
    int s;
    s = 0;
    for (int i = 0; i < ROUNDS; i++) begin
      s = s + ((((SHIFT_MAP >> i) & 16'h0001) != 16'h0000) ? 2 : 1);
    end
    return s % 28;
  endfunction

  localparam int TOT_MOD = total_shift();

  // Rotate a 28-bit half left by 0..27 positions.
  function automatic logic [27:0] rotl28(input logic [27:0] x, input int amt);
    logic [55:0] t;
    t = {x, x} << amt;
    return t[55:28];
  endfunction

  // Split C||D, rotate each half left independently, merge back.
  function automatic logic [55:0] rot_halves_l(input logic [55:0] cd, input int amt);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    return {rotl28(c, amt), rotl28(d, amt)};
  endfunction

  // Right rotation of both halves, expressed as the complementary left rotation.
  function automatic logic [55:0] rot_halves_r(input logic [55:0] cd, input int amt);
    return rot_halves_l(cd, (28 - amt) % 28);
  endfunction

  // Permuted choice 2: selects 48 of the 56 state bits (bit 1 = MSB numbering).
  function automatic logic [47:0] perm_pc2(input logic [55:0] s);
    return {s[42], s[39], s[45], s[32], s[55], s[51],
            s[53], s[28], s[41], s[50], s[35], s[46],
            s[33], s[37], s[44], s[52], s[30], s[48],
            s[40], s[49], s[29], s[36], s[43], s[54],
            s[15], s[4],  s[25], s[19], s[9],  s[1],
            s[26], s[16], s[5],  s[11], s[23], s[8],
            s[12], s[7],  s[17], s[0],  s[22], s[3],
            s[10], s[14], s[6],  s[20], s[27], s[24]};
  endfunction

  state_t           state_q;
  logic             key_ready_q;
  logic             k_valid_q;
  logic [47:0]      k_q;
  logic [IDX_W-1:0] k_idx_q;
  logic             k_last_q;
  logic [55:0]      r_q;
  logic             dec_q;

  logic [55:0]      r_load_d;
  logic [IDX_W-1:0] idx_load_d;
  logic [55:0]      r_adv_d;
  logic [IDX_W-1:0] idx_adv_d;
  logic             last_adv_d;
  logic             accept_d;
  logic             hs_d;

  // Next-state datapath: load values from the incoming key, advance values from r.
  always_comb begin
    r_load_d   = dec_i ? rot_halves_l(key_i, TOT_MOD)
                       : rot_halves_l(key_i, shift_of('0));
    idx_load_d = dec_i ? LAST_IDX : '0;
    idx_adv_d  = dec_q ? (k_idx_q - IDX_W'(1)) : (k_idx_q + IDX_W'(1));
    r_adv_d    = dec_q ? rot_halves_r(r_q, shift_of(k_idx_q))
                       : rot_halves_l(r_q, shift_of(idx_adv_d));
    last_adv_d = dec_q ? (idx_adv_d == '0) : (idx_adv_d == LAST_IDX);
    // A key presented together with abort is deliberately refused.
    accept_d   = key_valid_i & key_ready_q & ~abort_i;
    hs_d       = k_valid_q & k_ready_i;
  end

  // Control FSM with fully registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      key_ready_q <= 1'b0;
      k_valid_q   <= 1'b0;
      k_q         <= '0;
      k_idx_q     <= '0;
      k_last_q    <= 1'b0;
      r_q         <= '0;
      dec_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          key_ready_q <= 1'b1;
          if (accept_d) begin
            state_q     <= S_RUN;
            key_ready_q <= 1'b0;
            k_valid_q   <= 1'b1;
            dec_q       <= dec_i;
            r_q         <= r_load_d;
            k_q         <= perm_pc2(r_load_d);
            k_idx_q     <= idx_load_d;
            k_last_q    <= (ROUNDS == 1);
          end
        end
        S_RUN: begin
          if (abort_i) begin
            state_q     <= S_IDLE;
            k_valid_q   <= 1'b0;
            k_last_q    <= 1'b0;
            key_ready_q <= 1'b1;
          end else if (hs_d) begin
            if (k_last_q) begin
              state_q     <= S_IDLE;
              k_valid_q   <= 1'b0;
              k_last_q    <= 1'b0;
              key_ready_q <= 1'b1;
              // A finished decrypt run unwinds its last rotation, so r
              // returns to the originally loaded key.
              if (dec_q) begin
                r_q <= r_adv_d;
                k_q <= perm_pc2(r_adv_d);
              end
            end else begin
              r_q      <= r_adv_d;
              k_q      <= perm_pc2(r_adv_d);
              k_idx_q  <= idx_adv_d;
              k_last_q <= last_adv_d;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign key_ready_o = key_ready_q;
  assign k_valid_o   = k_valid_q;
  assign k_o         = k_q;
  assign k_idx_o     = k_idx_q;
  assign k_last_o    = k_last_q;
  assign r_o         = r_q;

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_schedule_seq
//  Description : Self-checking bench for key_schedule_seq (DES defaults plus a
//                ROUNDS=4 / SHIFT_MAP=0 instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_schedule_seq;

  localparam int          RA    = 16;
  localparam logic [15:0] MAP_A = 16'h7EFC;
  localparam int          RB    = 4;
  localparam logic [15:0] MAP_B = 16'h0000;

  localparam int PC2T [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                               23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                               41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                               44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  logic        clk;
  logic        rst_n;
  logic        key_valid, key_ready, dec, abort, k_valid, k_ready, k_last;
  logic [55:0] key, r;
  logic [47:0] k;
  logic [3:0]  k_idx;

  logic        b_key_valid, b_key_ready, b_dec, b_abort, b_k_valid, b_k_ready, b_k_last;
  logic [55:0] b_key, b_r;
  logic [47:0] b_k;
  logic [3:0]  b_k_idx;

  int n_cmp = 0;
  int n_err = 0;

  key_schedule_seq dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid_i(key_valid), .key_ready_o(key_ready), .key_i(key), .dec_i(dec),
    .abort_i(abort), .k_valid_o(k_valid), .k_ready_i(k_ready), .k_o(k),
    .k_idx_o(k_idx), .k_last_o(k_last), .r_o(r)
  );

  key_schedule_seq #(.ROUNDS(RB), .SHIFT_MAP(MAP_B), .IDX_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .key_valid_i(b_key_valid), .key_ready_o(b_key_ready), .key_i(b_key), .dec_i(b_dec),
    .abort_i(b_abort), .k_valid_o(b_k_valid), .k_ready_i(b_k_ready), .k_o(b_k),
    .k_idx_o(b_k_idx), .k_last_o(b_k_last), .r_o(b_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [27:0] rl(input logic [27:0] x, input int n);
    logic [27:0] y;
    y = x;
    for (int i = 0; i < n % 28; i++) y = {y[26:0], y[27]};
    return y;
  endfunction

  // Round key j state: each half rotated left by the cumulative shift of rounds 0..j.
  function automatic logic [55:0] model_r(input logic [55:0] kin, input logic [15:0] map, input int j);
    int cum;
    cum = 0;
    for (int i = 0; i <= j; i++) cum += map[i] ? 2 : 1;
    return {rl(kin[55:28], cum), rl(kin[27:0], cum)};
  endfunction

  function automatic logic [47:0] model_k(input logic [55:0] s);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = s[56 - PC2T[i]];
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (key_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("key_ready_wait", {63'd0, key_ready}, 64'd1);
  endtask

  // One complete load on the default instance, checked emission by emission.
  task automatic do_load(input logic [55:0] kin, input bit d, input int stall_at, input int stall_n,
                         input int abort_at, input bit rnd_ready, input bit junk,
                         output int nemit, output logic [47:0] first_k,
                         output logic [55:0] first_r, output logic [47:0] last_k);
    int  j, e, stall_rem, guard;
    bit  done;
    logic [55:0] er;
    nemit = 0; first_k = '0; first_r = '0; last_k = '0;
    stall_rem = stall_n; e = 0; done = 0; guard = 0;
    wait_ready();
    key_valid = 1'b1; key = kin; dec = d; k_ready = 1'b0;
    @(negedge clk);
    key_valid = 1'b0;
    key = {$urandom, $urandom};
    dec = ~d;
    check("load_key_ready", {63'd0, key_ready}, 64'd0);
    while (!done) begin
      j = d ? RA - 1 - e : e;
      if (k_valid !== 1'b1 || guard > 400) begin
        check("k_valid_run", {63'd0, k_valid}, 64'd1);
        if (k_valid === 1'b1) check("run_guard", 64'(guard), 64'd400);
        done = 1;
      end else begin
        er = model_r(kin, MAP_A, j);
        check("r", {8'd0, r}, {8'd0, er});
        check("k", {16'd0, k}, {16'd0, model_k(er)});
        check("k_idx", 64'(k_idx), 64'(j));
        check("k_last", {63'd0, k_last}, {63'd0, (e == RA - 1)});
        if (e == 0) begin first_k = k; first_r = r; end
        last_k = k;
        key_valid = junk && (e < RA - 1);
        if (j == abort_at) begin
          abort = 1'b1; k_ready = 1'b1;
          @(negedge clk);
          abort = 1'b0; k_ready = 1'b0; key_valid = 1'b0;
          check("abort_k_valid", {63'd0, k_valid}, 64'd0);
          check("abort_key_ready", {63'd0, key_ready}, 64'd1);
          done = 1;
        end else if (j == stall_at && stall_rem > 0) begin
          k_ready = 1'b0; stall_rem--;
          @(negedge clk);
        end else if (rnd_ready && $urandom_range(0, 2) == 0) begin
          k_ready = 1'b0;
          @(negedge clk);
        end else begin
          k_ready = 1'b1; nemit++;
          @(negedge clk);
          k_ready = 1'b0;
          if (e == RA - 1) begin
            key_valid = 1'b0;
            check("end_k_valid", {63'd0, k_valid}, 64'd0);
            check("end_key_ready", {63'd0, key_ready}, 64'd1);
            if (d) check("end_r_unwound", {8'd0, r}, {8'd0, kin});
            done = 1;
          end else begin
            e++;
          end
        end
        guard++;
      end
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int          n;
    logic [47:0] fk, lk;
    logic [55:0] fr, bk;
    int          g;
    logic [55:0] rk;
    bit          rd;

    rst_n = 1'b0; key_valid = 0; key = '0; dec = 0; abort = 0; k_ready = 0;
    b_key_valid = 0; b_key = '0; b_dec = 0; b_abort = 0; b_k_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_k_valid", {63'd0, k_valid}, 64'd0);
    check("rst_k", {16'd0, k}, 64'd0);
    check("rst_r", {8'd0, r}, 64'd0);
    check("rst_k_idx", 64'(k_idx), 64'd0);
    check("rst_k_last", {63'd0, k_last}, 64'd0);
    check("rst_key_ready", {63'd0, key_ready}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_key_ready", {63'd0, key_ready}, 64'd1);

    // Forward DES reference vector.
    do_load(56'hF0CCAAF556678F, 1'b0, -1, 0, -1, 1'b0, 1'b0, n, fk, fr, lk);
    check("fwd_k0", {16'd0, fk}, {16'd0, 48'h1B02EFFC7072});
    check("fwd_r0", {8'd0, fr}, {8'd0, 56'hE19955FAACCF1E});
    check("fwd_k15", {16'd0, lk}, {16'd0, 48'hCB3D8B0E17F5});
    check("fwd_count", 64'(n), 64'd16);

    // Reverse DES reference vector.
    do_load(56'hF0CCAAF556678F, 1'b1, -1, 0, -1, 1'b0, 1'b0, n, fk, fr, lk);
    check("rev_first_k", {16'd0, fk}, {16'd0, 48'hCB3D8B0E17F5});
    check("rev_first_r", {8'd0, fr}, {8'd0, 56'hF0CCAAF556678F});
    check("rev_last_k", {16'd0, lk}, {16'd0, 48'h1B02EFFC7072});
    check("rev_count", 64'(n), 64'd16);

    // Backpressure: 5 stalled cycles at k_idx=3, stray key_valid during run.
    do_load(56'hF0CCAAF556678F, 1'b0, 3, 5, -1, 1'b0, 1'b1, n, fk, fr, lk);
    check("bp_count", 64'(n), 64'd16);
    check("bp_last_k", {16'd0, lk}, {16'd0, 48'hCB3D8B0E17F5});

    // Abort at k_idx=7 together with k_ready, then a fresh load.
    do_load(56'hF0CCAAF556678F, 1'b0, -1, 0, 7, 1'b0, 1'b0, n, fk, fr, lk);
    check("abort_count", 64'(n), 64'd7);
    do_load(56'hF0CCAAF556678F, 1'b0, -1, 0, -1, 1'b0, 1'b0, n, fk, fr, lk);
    check("reload_k0", {16'd0, fk}, {16'd0, 48'h1B02EFFC7072});

    // Abort in IDLE together with key_valid: key must be refused.
    wait_ready();
    key_valid = 1'b1; abort = 1'b1; key = 56'h123456789ABCDE;
    @(negedge clk);
    key_valid = 1'b0; abort = 1'b0;
    check("idle_abort_k_valid", {63'd0, k_valid}, 64'd0);
    check("idle_abort_key_ready", {63'd0, key_ready}, 64'd1);

    // Randomized keys, directions and consumer backpressure.
    for (int t = 0; t < 4; t++) begin
      rk = {$urandom, $urandom};
      rd = 1'($urandom_range(0, 1));
      do_load(rk, rd, -1, 0, -1, 1'b1, 1'b1, n, fk, fr, lk);
      check("rnd_count", 64'(n), 64'd16);
    end

    // Reset in the middle of a run.
    wait_ready();
    key_valid = 1'b1; key = {$urandom, $urandom}; dec = 1'b0;
    @(negedge clk);
    key_valid = 1'b0; k_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    k_ready = 1'b0;
    check("midrst_k_valid", {63'd0, k_valid}, 64'd0);
    check("midrst_k", {16'd0, k}, 64'd0);
    check("midrst_r", {8'd0, r}, 64'd0);
    check("midrst_k_idx", 64'(k_idx), 64'd0);
    rst_n = 1'b1;
    k_ready = 1'b1;
    repeat (3) @(negedge clk);
    k_ready = 1'b0;
    check("after_rst_k_valid", {63'd0, k_valid}, 64'd0);

    // ROUNDS=4, SHIFT_MAP=0, reverse order.
    bk = {$urandom, $urandom};
    g = 0;
    while (b_key_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    check("b_key_ready", {63'd0, b_key_ready}, 64'd1);
    b_key_valid = 1'b1; b_key = bk; b_dec = 1'b1;
    @(negedge clk);
    b_key_valid = 1'b0; b_k_ready = 1'b1;
    check("b_first_r_rotl4", {8'd0, b_r},
          {8'd0, rl(bk[55:28], 4), rl(bk[27:0], 4)});
    for (int e = 0; e < RB; e++) begin
      check("b_k_valid", {63'd0, b_k_valid}, 64'd1);
      check("b_r", {8'd0, b_r}, {8'd0, model_r(bk, MAP_B, RB - 1 - e)});
      check("b_k", {16'd0, b_k}, {16'd0, model_k(model_r(bk, MAP_B, RB - 1 - e))});
      check("b_k_idx", 64'(b_k_idx), 64'(RB - 1 - e));
      check("b_k_last", {63'd0, b_k_last}, {63'd0, (e == RB - 1)});
      @(negedge clk);
    end
    b_k_ready = 1'b0;
    check("b_end_k_valid", {63'd0, b_k_valid}, 64'd0);
    check("b_final_r_key", {8'd0, b_r}, {8'd0, bk});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
